// File: rtl/bar_level_encoder_pkg.sv
// rtl/bar_level_encoder_pkg.sv - shared constants, level type and level helpers
package bar_level_encoder_pkg;
  localparam int NUM_BARS     = 16;
  localparam int SEGS         = 18;
  localparam int BINS_PER_BAR = 4;
  localparam int MAG_W        = 16;
  localparam int MAG_SHIFT    = 11;
  localparam int LVL_W        = $clog2(SEGS + 1);
  localparam int IDX_W        = $clog2(NUM_BARS + 1);
  localparam int CNT_W        = $clog2(BINS_PER_BAR);

  typedef logic [LVL_W-1:0] level_t;
  typedef logic [MAG_W-1:0] mag_t;
  typedef enum logic {ST_ACCUM = 1'b0, ST_FILL = 1'b1} state_t;

  function automatic logic [SEGS-1:0] level_to_mask(level_t lvl);
    logic [SEGS-1:0] mask;
    for (int i = 0; i < SEGS; i++) mask[i] = (level_t'(i) < lvl);
    return mask;
  endfunction

  function automatic level_t mag_to_level(mag_t gmax);
    mag_t scaled;
    scaled = gmax >> MAG_SHIFT;
    return (scaled > mag_t'(SEGS)) ? level_t'(SEGS) : level_t'(scaled);
  endfunction
endpackage

// File: rtl/bar_level_encoder_if.sv
// rtl/bar_level_encoder_if.sv - spectrum bin stream between source and encoder
interface bar_level_encoder_if;
  import bar_level_encoder_pkg::*;

  logic bin_valid;
  mag_t bin_mag;
  logic bin_last;
  logic bin_ready;

  modport master (output bin_valid, output bin_mag, output bin_last, input bin_ready);
  modport slave  (input bin_valid, input bin_mag, input bin_last, output bin_ready);
endinterface

// File: rtl/bar_level_encoder_bar_peak_hold.sv
// rtl/bar_level_encoder_bar_peak_hold.sv - one bar's shadow level with peak hold and linear decay
module bar_peak_hold
  import bar_level_encoder_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en,
  input  level_t new_level,
  output level_t level
);
  level_t level_q, level_d;

  // A lower new level implies level_q >= 1, so the decrement never wraps.
  always_comb begin
    level_d = level_q;
    if (wr_en) begin
      if (new_level >= level_q) level_d = new_level;
      else                      level_d = level_q - level_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  assign level = level_q;
endmodule

// File: rtl/bar_level_encoder.sv
// rtl/bar_level_encoder.sv - groups spectrum bins into peak-hold bars, reloads masks on frame_sync
module bar_level_encoder
  import bar_level_encoder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  bar_level_encoder_if.slave       bin_if,
  input  logic                     frame_sync,
  output logic                     frame_done,
  output logic [NUM_BARS*SEGS-1:0] bars
);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_BARS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BARS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BINS_PER_BAR - 1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         bar_idx_q, bar_idx_d;
  logic [CNT_W-1:0]         bin_cnt_q, bin_cnt_d;
  mag_t                     peak_q, peak_d;
  logic                     frame_done_q, frame_done_d;
  logic [NUM_BARS*SEGS-1:0] bars_q, bars_d;

  logic                accept;
  logic                wr_any;
  level_t              new_level;
  logic [NUM_BARS-1:0] wr_en;
  level_t              shadow [NUM_BARS];
  mag_t                gmax;
  logic [IDX_W-1:0]    idx_next;

  assign bin_if.bin_ready = (state_q == ST_ACCUM);
  assign accept           = bin_if.bin_valid & bin_if.bin_ready;
  assign gmax             = (bin_if.bin_mag > peak_q) ? bin_if.bin_mag : peak_q;
  assign idx_next         = bar_idx_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    bar_idx_d    = bar_idx_q;
    bin_cnt_d    = bin_cnt_q;
    peak_d       = peak_q;
    frame_done_d = 1'b0;
    wr_any       = 1'b0;
    new_level    = '0;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          // Past the last bar, bins are swallowed until bin_last arrives.
          if (bar_idx_q != IDX_END) begin
            if (bin_if.bin_last || (bin_cnt_q == CNT_LAST)) begin
              wr_any    = 1'b1;
              new_level = mag_to_level(gmax);
              bar_idx_d = idx_next;
              bin_cnt_d = '0;
              peak_d    = '0;
            end else begin
              peak_d    = gmax;
              bin_cnt_d = bin_cnt_q + CNT_W'(1);
            end
          end
          if (bin_if.bin_last) begin
            bin_cnt_d = '0;
            peak_d    = '0;
            if (bar_idx_d != IDX_END) begin
              state_d = ST_FILL;
            end else begin
              frame_done_d = 1'b1;
              bar_idx_d    = '0;
            end
          end
        end
      end
      ST_FILL: begin
        // Bars with no bins this frame get a zero level, i.e. decay by one.
        wr_any    = 1'b1;
        bar_idx_d = idx_next;
        if (bar_idx_q == IDX_LAST) begin
          frame_done_d = 1'b1;
          bar_idx_d    = '0;
          state_d      = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_BARS; k++) wr_en[k] = wr_any && (bar_idx_q == IDX_W'(k));
  end

  // Shadow levels are flops, so a write on the sync edge only shows at the next sync.
  always_comb begin
    bars_d = bars_q;
    if (frame_sync) begin
      for (int k = 0; k < NUM_BARS; k++) bars_d[k*SEGS +: SEGS] = level_to_mask(shadow[k]);
    end
  end

  for (genvar k = 0; k < NUM_BARS; k++) begin : g_bar
    bar_peak_hold u_hold (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en[k]),
      .new_level (new_level),
      .level     (shadow[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      bar_idx_q    <= '0;
      bin_cnt_q    <= '0;
      peak_q       <= '0;
      frame_done_q <= 1'b0;
      bars_q       <= '0;
    end else begin
      state_q      <= state_d;
      bar_idx_q    <= bar_idx_d;
      bin_cnt_q    <= bin_cnt_d;
      peak_q       <= peak_d;
      frame_done_q <= frame_done_d;
      bars_q       <= bars_d;
    end
  end

  assign frame_done = frame_done_q;
  assign bars       = bars_q;
endmodule
